// File: rtl/mem_port_sched.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Handles round-robin grant, byte-lane enables, load extension and access legality.
module mem_port_sched #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_memop,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              busy,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              last_gnt_q;   // 1 = D was granted last
  logic              gnt_q;        // 1 = D owns the current transaction
  logic              we_q;
  logic [2:0]        memop_q;
  logic [1:0]        off_q;
  logic              mem_en_q;
  logic [3:0]        mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              if_done_q, if_err_q, d_done_q, d_err_q;
  logic [31:0]       if_rdata_q, d_rdata_q;

  logic              any_req, pick_d, acc_err, is_store;
  logic [31:0]       gnt_addr, st_wdata, shifted, ext;
  logic [3:0]        st_be;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

  always_comb begin
    any_req  = if_req | d_req;
    pick_d   = d_req & (~if_req | ~last_gnt_q);
    gnt_addr = pick_d ? d_addr : if_addr;
    is_store = pick_d & d_we;
    acc_err  = 1'b0;
    if (pick_d) begin
      if (d_we)
        acc_err = d_memop[2] | (d_memop[1:0] == 2'b11);
      else
        acc_err = (d_memop[1:0] == 2'b11) | (d_memop == 3'b110);
      if (d_memop[1:0] == 2'b01 && d_addr[0])
        acc_err = 1'b1;
      if (d_memop[1:0] == 2'b10 && d_addr[1:0] != 2'b00)
        acc_err = 1'b1;
    end else begin
      acc_err = (if_addr[1:0] != 2'b00);
    end

    st_be    = 4'b0000;
    st_wdata = '0;
    if (is_store) begin
      case (d_memop[1:0])
        2'b00:   begin st_be = 4'b0001 << d_addr[1:0]; st_wdata = {4{d_wdata[7:0]}};  end
        2'b01:   begin st_be = 4'b0011 << d_addr[1:0]; st_wdata = {2{d_wdata[15:0]}}; end
        default: begin st_be = 4'b1111;                st_wdata = d_wdata;            end
      endcase
    end

    shifted = mem_rdata >> {off_q, 3'b000};
    case (memop_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = mem_rdata;
    endcase
    if (!gnt_q) ext = mem_rdata;

    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = acc_err ? DONE : ACCESS;
      ACCESS:  state_d = (gnt_q && we_q) ? DONE : RESP;
      RESP:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      memop_q     <= '0;
      off_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          gnt_q      <= pick_d;
          last_gnt_q <= pick_d;
          we_q       <= pick_d & d_we;
          memop_q    <= d_memop;
          off_q      <= gnt_addr[1:0];
          if (acc_err) begin
            if (pick_d) begin d_done_q  <= 1'b1; d_err_q  <= 1'b1; d_rdata_q  <= '0; end
            else        begin if_done_q <= 1'b1; if_err_q <= 1'b1; if_rdata_q <= '0; end
          end else begin
            mem_en_q    <= 1'b1;
            mem_addr_q  <= gnt_addr[ADDR_W+1:2];
            mem_we_q    <= st_be;
            mem_wdata_q <= st_wdata;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= '0;
          if (gnt_q && we_q) begin
            d_done_q <= 1'b1;
            d_err_q  <= 1'b0;
          end
        end
        RESP: begin
          if (gnt_q) begin d_done_q  <= 1'b1; d_err_q  <= 1'b0; d_rdata_q  <= ext; end
          else       begin if_done_q <= 1'b1; if_err_q <= 1'b0; if_rdata_q <= ext; end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched with a behavioural byte-lane RAM model.
module tb_mem_port_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [2:0]  d_memop = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_done, d_err;
  logic [31:0] d_rdata;
  logic        busy, mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ram [0:16383];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_sched #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_memop(d_memop), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Result fields of the last transaction issued by txn.
  logic [31:0] r_rd, r_wd;
  logic        r_er, r_oth, r_after;
  int          r_lat, r_en;
  logic [3:0]  r_we;
  logic [13:0] r_a;

  task automatic do_reset();
    if_req = 0; d_req = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic txn(input logic is_if, input logic we, input logic [2:0] op,
                     input logic [31:0] addr, input logic [31:0] wd);
    for (int k = 0; k < 10 && busy; k++) begin @(posedge clk); #1; end
    if (is_if) begin if_req = 1; if_addr = addr; end
    else begin d_req = 1; d_we = we; d_memop = op; d_addr = addr; d_wdata = wd; end
    r_lat = 99; r_en = 0; r_oth = 0; r_we = '0; r_a = '0; r_wd = '0; r_rd = '0; r_er = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (mem_en && r_en == 0) begin r_en = n; r_we = mem_we; r_a = mem_addr; r_wd = mem_wdata; end
      if (is_if ? d_done : if_done) r_oth = 1;
      if (is_if ? if_done : d_done) begin
        r_lat = n;
        r_rd  = is_if ? if_rdata : d_rdata;
        r_er  = is_if ? if_err : d_err;
        break;
      end
    end
    if_req = 0; d_req = 0;
    @(posedge clk); #1;
    r_after = is_if ? if_done : d_done;
  endtask

  task automatic test_reset();
    rst = 1; #1;
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_mem got %b/%b/%h/%h exp all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_checks++;
    if ({if_done, if_err, if_rdata, d_done, d_err, d_rdata, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outs got ifd=%b ife=%b ifr=%h dd=%b de=%b dr=%h busy=%b exp all 0",
                         if_done, if_err, if_rdata, d_done, d_err, d_rdata, busy);
    end
    do_reset();
  endtask

  task automatic test_tie();
    logic [3:0] seq = '0;
    int cnt = 0;
    logic both = 0;
    do_reset();
    if_addr = 32'h10; d_we = 0; d_memop = 3'b010; d_addr = 32'h10;
    if_req = 1; d_req = 1;
    for (int c = 0; c < 40 && cnt < 4; c++) begin
      @(posedge clk); #1;
      if (if_done && d_done) both = 1;
      if (if_done) begin seq[cnt] = 1'b0; cnt++; end
      else if (d_done) begin seq[cnt] = 1'b1; cnt++; end
    end
    if_req = 0; d_req = 0;
    n_checks++;
    if (cnt !== 4) begin n_fail++; $display("FAIL tie_count got %0d exp 4", cnt); end
    n_checks++;
    if (seq !== 4'b1010) begin n_fail++; $display("FAIL tie_order got %b exp 1010 (bit0 first, 1=D)", seq); end
    n_checks++;
    if (both !== 1'b0) begin n_fail++; $display("FAIL tie_double_done got %b exp 0", both); end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0010, '0);
    n_checks++;
    if (r_en !== 1 || r_a !== 14'd4 || r_we !== 4'b0000) begin
      n_fail++; $display("FAIL fetch_access got en_cyc=%0d addr=%h we=%b exp 1/0004/0000", r_en, r_a, r_we);
    end
    n_checks++;
    if (r_lat !== 3 || r_rd !== 32'h0050_0093 || r_er !== 1'b0) begin
      n_fail++; $display("FAIL fetch_data got lat=%0d rd=%h err=%b exp 3/00500093/0", r_lat, r_rd, r_er);
    end
    n_checks++;
    if (r_oth !== 1'b0 || r_after !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pulse got d_done_seen=%b done_after=%b exp 0/0", r_oth, r_after);
    end
    txn(1'b1, 1'b0, 3'b010, 32'h0000_0012, '0);
    n_checks++;
    if (r_lat !== 1 || r_er !== 1'b1 || r_rd !== '0 || r_en !== 0) begin
      n_fail++; $display("FAIL fetch_misalign got lat=%0d err=%b rd=%h en_cyc=%0d exp 1/1/0/0", r_lat, r_er, r_rd, r_en);
    end
  endtask

  task automatic test_byte();
    txn(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    n_checks++;
    if (r_we !== 4'b1000 || r_a !== 14'h40 || r_wd !== 32'hA5A5_A5A5) begin
      n_fail++; $display("FAIL sb_lanes got we=%b addr=%h wd=%h exp 1000/0040/a5a5a5a5", r_we, r_a, r_wd);
    end
    n_checks++;
    if (r_lat !== 2 || r_er !== 1'b0) begin n_fail++; $display("FAIL sb_latency got %0d err=%b exp 2/0", r_lat, r_er); end
    txn(1'b0, 1'b0, 3'b000, 32'h0000_0103, '0);
    n_checks++;
    if (r_rd !== 32'hFFFF_FFA5 || r_lat !== 3) begin n_fail++; $display("FAIL lb got %h lat=%0d exp ffffffa5/3", r_rd, r_lat); end
    txn(1'b0, 1'b0, 3'b100, 32'h0000_0103, '0);
    n_checks++;
    if (r_rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL lbu got %h exp 000000a5", r_rd); end
  endtask

  task automatic test_half();
    txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_8001);
    n_checks++;
    if (r_we !== 4'b1100 || r_a !== 14'h80 || r_wd !== 32'h8001_8001) begin
      n_fail++; $display("FAIL sh_lanes got we=%b addr=%h wd=%h exp 1100/0080/80018001", r_we, r_a, r_wd);
    end
    txn(1'b0, 1'b0, 3'b001, 32'h0000_0202, '0);
    n_checks++;
    if (r_rd !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh got %h exp ffff8001", r_rd); end
    txn(1'b0, 1'b0, 3'b101, 32'h0000_0202, '0);
    n_checks++;
    if (r_rd !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu got %h exp 00008001", r_rd); end
  endtask

  task automatic test_word();
    txn(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678);
    n_checks++;
    if (r_we !== 4'b1111 || r_a !== 14'h8 || r_wd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL sw_lanes got we=%b addr=%h wd=%h exp 1111/0008/12345678", r_we, r_a, r_wd);
    end
    txn(1'b0, 1'b0, 3'b000, 32'h0000_0021, '0);
    n_checks++;
    if (r_rd !== 32'h0000_0056) begin n_fail++; $display("FAIL lb_pos got %h exp 00000056", r_rd); end
    txn(1'b0, 1'b0, 3'b001, 32'h0000_0022, '0);
    n_checks++;
    if (r_rd !== 32'h0000_1234) begin n_fail++; $display("FAIL lh_upper got %h exp 00001234", r_rd); end
    txn(1'b0, 1'b0, 3'b010, 32'hFFFF_0010, '0);
    n_checks++;
    if (r_a !== 14'd4 || r_rd !== 32'h0050_0093 || r_er !== 1'b0) begin
      n_fail++; $display("FAIL wrap got addr=%h rd=%h err=%b exp 0004/00500093/0", r_a, r_rd, r_er);
    end
  endtask

  task automatic test_errors();
    txn(1'b0, 1'b0, 3'b010, 32'h0000_0006, '0);
    n_checks++;
    if (r_lat !== 1 || r_er !== 1'b1 || r_rd !== '0 || r_en !== 0) begin
      n_fail++; $display("FAIL lw_misalign got lat=%0d err=%b rd=%h en_cyc=%0d exp 1/1/0/0", r_lat, r_er, r_rd, r_en);
    end
    txn(1'b0, 1'b0, 3'b011, 32'h0000_0000, '0);
    n_checks++;
    if (r_lat !== 1 || r_er !== 1'b1 || r_rd !== '0 || r_en !== 0) begin
      n_fail++; $display("FAIL load_op011 got lat=%0d err=%b rd=%h en_cyc=%0d exp 1/1/0/0", r_lat, r_er, r_rd, r_en);
    end
    txn(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'hFF);
    n_checks++;
    if (r_er !== 1'b1 || r_en !== 0) begin
      n_fail++; $display("FAIL store_op100 got err=%b en_cyc=%0d exp 1/0", r_er, r_en);
    end
    txn(1'b0, 1'b0, 3'b001, 32'h0000_0201, '0);
    n_checks++;
    if (r_er !== 1'b1) begin n_fail++; $display("FAIL lh_misalign got err=%b exp 1", r_er); end
  endtask

  task automatic test_reset_mid();
    logic seen_done = 0;
    for (int k = 0; k < 10 && busy; k++) begin @(posedge clk); #1; end
    d_req = 1; d_we = 1; d_memop = 3'b000; d_addr = 32'h0000_0020; d_wdata = 32'hEE;
    @(posedge clk); #1;
    n_checks++;
    if (mem_en !== 1'b1) begin n_fail++; $display("FAIL midrst_access got mem_en=%b exp 1", mem_en); end
    rst = 1; d_req = 0; #1;
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, busy, d_done} !== '0) begin
      n_fail++; $display("FAIL midrst_outs got en=%b we=%b a=%h wd=%h busy=%b dd=%b exp all 0",
                         mem_en, mem_we, mem_addr, mem_wdata, busy, d_done);
    end
    repeat (3) begin @(posedge clk); #1; if (d_done) seen_done = 1; end
    rst = 0;
    @(posedge clk); #1;
    if (d_done) seen_done = 1;
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL midrst_nodone got %b exp 0", seen_done); end
    txn(1'b0, 1'b0, 3'b010, 32'h0000_0020, '0);
    n_checks++;
    if (r_lat !== 3 || r_rd !== 32'h1234_5678 || r_er !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after got lat=%0d rd=%h err=%b exp 3/12345678/0", r_lat, r_rd, r_er);
    end
  endtask

  initial begin
    ram[4] = 32'h0050_0093;
    test_reset();
    test_tie();
    test_fetch();
    test_byte();
    test_half();
    test_word();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_sched.md
Name: mem_port_sched

Overview:
- Sequences and shares one single-port synchronous data/instruction RAM between two requesters of the multi-cycle RV32I core: instruction fetch (IF) and load/store (D).
- Performs round-robin arbitration, word-address generation, and byte-lane write enables for sb/sh/sw.
- Performs load data lane selection with sign/zero extension for lb/lh/lw/lbu/lhu.
- Detects misaligned and illegal accesses.

Parameters:
- ADDR_W, 14, word-address width of the RAM. mem_addr = addr[ADDR_W+1:2]; higher address bits are ignored.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  32  instruction word, valid while if_done=1
- if_err  out  1  misaligned fetch, valid while if_done=1
- d_req  in  1  load/store request
- d_we  in  1  1=store, 0=load
- d_memop  in  3  MemOp: 000 b, 001 h, 010 w, 100 bu, 101 hu
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  32  extended load data, valid while d_done=1
- d_err  out  1  misaligned or illegal MemOp, valid while d_done=1
- busy  out  1  state != IDLE
- mem_en  out  1  RAM access enable
- mem_we  out  4  RAM byte write enables; bit i writes byte i (little-endian)
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid in the cycle after the enabled read edge

Behaviour:
- Reset (async):
  - State IDLE; last_gnt=D.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, done, err, rdata, busy.
  - Reset mid-operation abandons the transaction; no done pulse is issued.
- States: IDLE, ACCESS, RESP, DONE.
  - IDLE is the only state in which requests are sampled.
- Arbitration in IDLE:
  - Only one request high: grant that requester.
  - Both high: grant the requester not equal to last_gnt, then update last_gnt. After reset, fetch wins the first tie.
- Capture at grant: address, d_we, d_memop and d_wdata are registered. Requesters hold inputs and keep req high until their done pulse.
- Legality checks, evaluated at grant:
  - Fetch: addr[1:0] != 0 is an error.
  - D, halfword: addr[0] != 0 is an error.
  - D, word: addr[1:0] != 0 is an error.
  - Load MemOp in {011, 110, 111} is an error.
  - Store MemOp other than 000/001/010 is an error.
- Error path: at the grant edge go directly to DONE with mem_en=0. The requester sees done=1, err=1, rdata=0 in the next cycle. There is no RAM access.
- Legal access, on the grant edge:
  - mem_en=1 and mem_addr registered; state ACCESS for exactly one cycle.
- Store byte enables and data:
  - sb: mem_we = 0001 << off; mem_wdata = wdata[7:0] replicated ×4.
  - sh: mem_we = 0011 << off; mem_wdata = wdata[15:0] replicated ×2.
  - sw: mem_we = 1111; mem_wdata = wdata.
  - Loads and fetches: mem_we = 0000.
- Leaving ACCESS: mem_en and mem_we clear to 0.
  - Store: go to DONE. d_done high the next cycle. Latency from grant edge to done is 2 cycles.
  - Read: go to RESP.
- RESP, reads only:
  - Lane-select mem_rdata by the latched offset and extend it.
  - lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw/fetch pass through.
  - Register the result into rdata; go to DONE. Latency from grant edge to done is 3 cycles.
- DONE:
  - The granted requester's done=1 for exactly this cycle; the other requester's done stays 0.
  - rdata/err are held until the next done for that port.
  - Next state is IDLE. req is ignored in DONE, so a req still high is treated as a new request in the following IDLE cycle.
- Throughput: a back-to-back read uses 4 cycles (IDLE, ACCESS, RESP, DONE); a store uses 3.
- Wrap-around: address bits above ADDR_W+1 are discarded; no error is raised.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0010, RAM word 4 = 0x0050_0093 -> mem_en=1, mem_addr=4 one cycle after grant; if_done=1, if_rdata=0x0050_0093 three cycles after grant; d_done stays 0.
- Store sb d_addr=0x0000_0103, d_wdata=0x0000_00A5 -> mem_we=1000, mem_addr=0x40, mem_wdata=0xA5A5A5A5; d_done two cycles after grant. Then lb at the same address -> d_rdata=0xFFFF_FFA5; lbu -> 0x0000_00A5.
- Store sh d_addr=0x202, data 0x8001; then lh -> 0xFFFF_8001, lhu -> 0x0000_8001; mem_we=1100 on the store.
- if_req and d_req held high together for 4 transactions from reset -> grants IF, D, IF, D; no cycle with two done pulses.
- Misaligned lw d_addr=0x6, then illegal load MemOp 011 -> each gives d_done=1, d_err=1, d_rdata=0, with mem_en never asserted.
- Assert rst during the ACCESS cycle of a store -> all outputs 0 immediately, no d_done; after release, the next d_req completes normally.
